// File: rtl/proc_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions,
// the bubble instruction word, special register indices and the D/X latch type.
package proc_pkg;

  typedef enum logic [4:0] {
    OP_RTYPE = 5'b00000,
    OP_J     = 5'b00001,
    OP_BNE   = 5'b00010,
    OP_JAL   = 5'b00011,
    OP_JR    = 5'b00100,
    OP_ADDI  = 5'b00101,
    OP_BLT   = 5'b00110,
    OP_SW    = 5'b00111,
    OP_LW    = 5'b01000,
    OP_SETX  = 5'b10101,
    OP_BEX   = 5'b10110
  } opcode_e;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_MSB     = 26;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS_MSB     = 21;
  localparam int unsigned RS_LSB     = 17;
  localparam int unsigned RT_MSB     = 16;
  localparam int unsigned RT_LSB     = 12;

  localparam logic [31:0] NOP_INSN   = '0;
  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [4:0]  REG_STATUS = 5'd30;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid;
  } dxLatch_t;

  function automatic logic [4:0] getOpcode(input logic [31:0] insn);
    return insn[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [4:0] getRd(input logic [31:0] insn);
    return insn[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] getRs(input logic [31:0] insn);
    return insn[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] getRt(input logic [31:0] insn);
    return insn[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: F/D inputs, register file read port, execute controls,
// writeback port and D/X latch outputs. The slave side is the decode stage.
interface decode_stage_if;
  logic [31:0] fd_insn;
  logic [31:0] fd_pc;
  logic        fd_valid;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        x_flush;
  logic        x_hold;
  logic        w_we;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic        stall_fd;
  logic [31:0] dx_insn;
  logic [31:0] dx_pc;
  logic [31:0] dx_a;
  logic [31:0] dx_b;
  logic        dx_valid;

  modport master (
    output fd_insn, fd_pc, fd_valid, data_readRegA, data_readRegB,
           x_flush, x_hold, w_we, w_rd, w_data,
    input  ctrl_readRegA, ctrl_readRegB, stall_fd,
           dx_insn, dx_pc, dx_a, dx_b, dx_valid
  );

  modport slave (
    input  fd_insn, fd_pc, fd_valid, data_readRegA, data_readRegB,
           x_flush, x_hold, w_we, w_rd, w_data,
    output ctrl_readRegA, ctrl_readRegB, stall_fd,
           dx_insn, dx_pc, dx_a, dx_b, dx_valid
  );
endinterface

// File: rtl/decode_src_select.sv
// Combinational source-register select for the two register file read ports,
// with a flag per port saying the selected register is a real (nonzero) source.
module decode_src_select
  import proc_pkg::*;
(
  input  logic [31:0] insn,
  output logic [4:0]  srcA,
  output logic [4:0]  srcB,
  output logic        usedA,
  output logic        usedB
);

  logic unusedLowBits;
  assign unusedLowBits = ^insn[RT_LSB-1:0];

  // Pick the A/B source fields according to the instruction class
  always_comb begin
    srcA = REG_ZERO;
    srcB = REG_ZERO;
    case (getOpcode(insn))
      OP_RTYPE: begin
        srcA = getRs(insn);
        srcB = getRt(insn);
      end
      OP_ADDI, OP_LW: begin
        srcA = getRs(insn);
      end
      OP_SW: begin
        srcA = getRs(insn);
        srcB = getRd(insn);
      end
      OP_BNE, OP_BLT: begin
        srcA = getRd(insn);
        srcB = getRs(insn);
      end
      OP_JR: begin
        srcA = getRd(insn);
      end
      OP_BEX: begin
        srcA = REG_STATUS;
      end
      default: begin
        srcA = REG_ZERO;
        srcB = REG_ZERO;
      end
    endcase
  end

  // r0 never carries a dependency
  always_comb begin
    usedA = (srcA != REG_ZERO);
    usedB = (srcB != REG_ZERO);
  end

endmodule

// File: rtl/decode_stage.sv
// Operand-fetch stage: selects register file sources from the F/D instruction,
// captures operands into the D/X latch, inserts bubbles on load-use hazards and
// honours flush/hold requests from execute.
// Optional feature macro: DECODE_WB_BYPASS_EN (forward the writeback port into
// the operands when it targets a selected source in the same cycle).
module decode_stage
  import proc_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSN
) (
  input logic            clock,
  input logic            ctrl_reset,
  decode_stage_if.slave  bus
);

  localparam dxLatch_t BUBBLE = '{insn: NOP, pc: '0, a: '0, b: '0, valid: 1'b0};

  logic [4:0]  srcA;
  logic [4:0]  srcB;
  logic        usedA;
  logic        usedB;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        lu;
  dxLatch_t    dxQ;

  decode_src_select uSrcSel (
    .insn  (bus.fd_insn),
    .srcA  (srcA),
    .srcB  (srcB),
    .usedA (usedA),
    .usedB (usedB)
  );

  assign bus.ctrl_readRegA = srcA;
  assign bus.ctrl_readRegB = srcB;

`ifdef DECODE_WB_BYPASS_EN
  // Operands: zero for r0, writeback data when it targets the source, else RF data
  always_comb begin
    opA = '0;
    opB = '0;
    if (usedA) begin
      opA = (bus.w_we && bus.w_rd == srcA) ? bus.w_data : bus.data_readRegA;
    end
    if (usedB) begin
      opB = (bus.w_we && bus.w_rd == srcB) ? bus.w_data : bus.data_readRegB;
    end
  end
`else
  logic unusedWb;
  assign unusedWb = ^{bus.w_we, bus.w_rd, bus.w_data};

  // Operands: zero for r0, otherwise register file data
  always_comb begin
    opA = '0;
    opB = '0;
    if (usedA) opA = bus.data_readRegA;
    if (usedB) opB = bus.data_readRegB;
  end
`endif

  // Load-use hazard: lw in D/X writing a register the F/D instruction reads
  always_comb begin
    lu = dxQ.valid
      && (getOpcode(dxQ.insn) == OP_LW)
      && (getRd(dxQ.insn) != REG_ZERO)
      && bus.fd_valid
      && ((usedA && srcA == getRd(dxQ.insn)) || (usedB && srcB == getRd(dxQ.insn)));
  end

  // Stall F/D while held or bubbling for a hazard; flush and reset override
  always_comb begin
    bus.stall_fd = ~ctrl_reset & ~bus.x_flush & (bus.x_hold | lu);
  end

  // D/X latch update in priority order: reset, flush, hold, hazard, load
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      dxQ <= BUBBLE;
    end else if (bus.x_flush) begin
      dxQ <= BUBBLE;
    end else if (bus.x_hold) begin
      dxQ <= dxQ;
    end else if (lu) begin
      dxQ <= BUBBLE;
    end else begin
      dxQ.insn  <= bus.fd_valid ? bus.fd_insn : NOP;
      dxQ.pc    <= bus.fd_pc;
      dxQ.a     <= opA;
      dxQ.b     <= opB;
      dxQ.valid <= bus.fd_valid;
    end
  end

  assign bus.dx_insn  = dxQ.insn;
  assign bus.dx_pc    = dxQ.pc;
  assign bus.dx_a     = dxQ.a;
  assign bus.dx_b     = dxQ.b;
  assign bus.dx_valid = dxQ.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// traffic, compared against a behavioural model of the stage.
module tb_decode_stage;
  import proc_pkg::*;

  logic clock = 1'b0;
  logic ctrl_reset;
  decode_stage_if bus ();

  decode_stage #(.NOP(32'h0000_0000)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // Register file: combinational read of whatever the stage selects
  logic [31:0] rf [32];
  assign bus.data_readRegA = rf[bus.ctrl_readRegA];
  assign bus.data_readRegB = rf[bus.ctrl_readRegB];

  int passCnt = 0;
  int failCnt = 0;
  int totalCnt = 0;

  // Model of the D/X latch
  logic [31:0] mInsn, mPc, mA, mB;
  logic        mValid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  // Which registers an instruction reads, straight from the opcode table
  function automatic void sources(input logic [31:0] i, output logic [4:0] a, output logic [4:0] b);
    logic [4:0] rd, rs, rt;
    rd = i[26:22];
    rs = i[21:17];
    rt = i[16:12];
    a = 5'd0;
    b = 5'd0;
    case (i[31:27])
      5'd0:       begin a = rs; b = rt; end
      5'd5, 5'd8: begin a = rs; end
      5'd7:       begin a = rs; b = rd; end
      5'd2, 5'd6: begin a = rd; b = rs; end
      5'd4:       begin a = rd; end
      5'd22:      begin a = 5'd30; end
      default:    ;
    endcase
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (bus.w_we && bus.w_rd != 5'd0 && bus.w_rd == s) return bus.w_data;
`endif
    return rf[s];
  endfunction

  task automatic modelBubble();
    mInsn = 32'd0; mPc = 32'd0; mA = 32'd0; mB = 32'd0; mValid = 1'b0;
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc, input logic valid,
                       input logic flush, input logic hold);
    bus.fd_insn = insn; bus.fd_pc = pc; bus.fd_valid = valid;
    bus.x_flush = flush; bus.x_hold = hold;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check D/X after edge
  task automatic cycle(input string tag);
    logic [4:0] sa, sb, ldRd;
    logic luExp, stallExp;
    #3;
    sources(bus.fd_insn, sa, sb);
    ldRd = mInsn[26:22];
    luExp = mValid && (mInsn[31:27] == 5'd8) && (ldRd != 5'd0) && bus.fd_valid
            && (sa == ldRd || sb == ldRd);
    stallExp = !bus.x_flush && (bus.x_hold || luExp);
    check({tag, "/readA"}, {27'd0, bus.ctrl_readRegA}, {27'd0, sa});
    check({tag, "/readB"}, {27'd0, bus.ctrl_readRegB}, {27'd0, sb});
    check({tag, "/stall"}, {31'd0, bus.stall_fd}, {31'd0, stallExp});
    if (bus.x_flush || (!bus.x_hold && luExp)) begin
      modelBubble();
    end else if (!bus.x_hold) begin
      mInsn  = bus.fd_valid ? bus.fd_insn : 32'd0;
      mPc    = bus.fd_pc;
      mA     = operand(sa);
      mB     = operand(sb);
      mValid = bus.fd_valid;
    end
    @(posedge clock);
    #1;
    check({tag, "/dx_insn"},  bus.dx_insn, mInsn);
    check({tag, "/dx_pc"},    bus.dx_pc, mPc);
    check({tag, "/dx_a"},     bus.dx_a, mA);
    check({tag, "/dx_b"},     bus.dx_b, mB);
    check({tag, "/dx_valid"}, {31'd0, bus.dx_valid}, {31'd0, mValid});
  endtask

  // Asynchronous reset in the middle of a cycle, with hold raised to show stall drops
  task automatic midReset(input string tag);
    bus.x_hold = 1'b1;
    ctrl_reset = 1'b1;
    #1;
    modelBubble();
    check({tag, "/dx_valid"}, {31'd0, bus.dx_valid}, 32'd0);
    check({tag, "/dx_insn"},  bus.dx_insn, 32'd0);
    check({tag, "/stall"},    {31'd0, bus.stall_fd}, 32'd0);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    bus.x_hold = 1'b0;
    check({tag, "/held_valid"}, {31'd0, bus.dx_valid}, 32'd0);
  endtask

  initial begin
    logic [4:0] ops [12];
    logic [31:0] heldInsn;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd8, 5'd21, 5'd22};

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hBAD0_0000;
    rf[1] = 32'd5;
    rf[2] = 32'd7;

    ctrl_reset = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    bus.w_we = 1'b0; bus.w_rd = 5'd0; bus.w_data = 32'd0;
    modelBubble();
    #1;
    check("reset/dx_valid", {31'd0, bus.dx_valid}, 32'd0);
    check("reset/dx_insn",  bus.dx_insn, 32'd0);
    check("reset/stall",    {31'd0, bus.stall_fd}, 32'd0);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;

    // add r3,r1,r2
    drive(mk(5'd0, 5'd3, 5'd1, 5'd2), 32'd100, 1'b1, 1'b0, 1'b0);
    cycle("add");
    check("add/a5", bus.dx_a, 32'd5);
    check("add/b7", bus.dx_b, 32'd7);

    // lw r4 followed by add r5,r4,r1: one bubble, then the add
    drive(mk(5'd8, 5'd4, 5'd9, 5'd0), 32'd101, 1'b1, 1'b0, 1'b0);
    cycle("lw4");
    drive(mk(5'd0, 5'd5, 5'd4, 5'd1), 32'd102, 1'b1, 1'b0, 1'b0);
    cycle("lu_stall");
    check("lu_stall/bubble", {31'd0, bus.dx_valid}, 32'd0);
    cycle("lu_release");
    check("lu_release/add", bus.dx_insn, mk(5'd0, 5'd5, 5'd4, 5'd1));

    // lw r0 followed by add r5,r0,r1: no stall, r0 reads 0
    drive(mk(5'd8, 5'd0, 5'd9, 5'd0), 32'd103, 1'b1, 1'b0, 1'b0);
    cycle("lw0");
    drive(mk(5'd0, 5'd5, 5'd0, 5'd1), 32'd104, 1'b1, 1'b0, 1'b0);
    cycle("lw0_use");
    check("lw0_use/a0", bus.dx_a, 32'd0);
    check("lw0_use/valid", {31'd0, bus.dx_valid}, 32'd1);

    // hold for three cycles, then flush together with hold
    heldInsn = mk(5'd5, 5'd7, 5'd2, 5'd0);
    drive(heldInsn, 32'd105, 1'b1, 1'b0, 1'b0);
    cycle("pre_hold");
    for (int i = 0; i < 3; i++) begin
      drive(mk(5'd0, 5'd1, 5'd2, 5'd3), 32'd200 + i, 1'b1, 1'b0, 1'b1);
      cycle("hold");
      check("hold/insn", bus.dx_insn, heldInsn);
    end
    drive(mk(5'd0, 5'd1, 5'd2, 5'd3), 32'd210, 1'b1, 1'b1, 1'b1);
    cycle("flush_hold");
    check("flush_hold/bubble", {31'd0, bus.dx_valid}, 32'd0);

    // sw r6,0(r1) with writeback to r6 in the same cycle
    bus.w_we = 1'b1; bus.w_rd = 5'd6; bus.w_data = 32'h0000_DEAD;
    drive(mk(5'd7, 5'd6, 5'd1, 5'd0), 32'd106, 1'b1, 1'b0, 1'b0);
    cycle("sw_wb");
`ifdef DECODE_WB_BYPASS_EN
    check("sw_wb/b", bus.dx_b, 32'h0000_DEAD);
`else
    check("sw_wb/b", bus.dx_b, rf[6]);
`endif
    bus.w_we = 1'b0;

    // load something real, then reset asynchronously mid-stream
    drive(mk(5'd8, 5'd3, 5'd1, 5'd0), 32'd107, 1'b1, 1'b0, 1'b0);
    cycle("pre_reset");
    midReset("midreset");

    // random traffic, small register numbers so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      if (n == 200) midReset("rnd_reset");
      bus.fd_insn  = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom)};
      bus.fd_pc    = $urandom;
      bus.fd_valid = ($urandom_range(0, 7) != 0);
      bus.x_flush  = ($urandom_range(0, 15) == 0);
      bus.x_hold   = ($urandom_range(0, 7) == 0);
      bus.w_we     = $urandom_range(0, 1) != 0;
      bus.w_rd     = 5'($urandom_range(0, 7));
      bus.w_data   = $urandom;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Operand-fetch stage of the five-stage pipeline, sitting between the F/D latch and the execute stage. It decodes source-register numbers from the F/D instruction and drives the register file's read ports. It captures the register file's read data into the D/X pipeline latch. It also detects load-use hazards and inserts bubbles, and honours flush (taken branch/jump) and hold (multdiv busy) requests from execute.

## Interface
- `NOP`, default 32'b0, instruction word loaded into D/X for a bubble
- `clock`  in  1  rising-edge clock
- `ctrl_reset`  in  1  asynchronous, active-high reset
- `fd_insn`  in  32  instruction from F/D latch
- `fd_pc`  in  32  PC+1 from F/D latch
- `fd_valid`  in  1  F/D holds a real instruction
- `ctrl_readRegA`, `ctrl_readRegB`  out  5  register file read selects (combinational)
- `data_readRegA`, `data_readRegB`  in  32  register file read data
- `x_flush`  in  1  execute resolved a taken branch/jump this cycle
- `x_hold`  in  1  multdiv busy; freeze D/X
- `w_we`, `w_rd`, `w_data`  in  1/5/32  writeback port (same values driven to the register file)
- `stall_fd`  out  1  F/D and PC must not advance this cycle
- `dx_insn`, `dx_pc`, `dx_a`, `dx_b`  out  32 each  D/X latch contents
- `dx_valid`  out  1  D/X holds a real instruction

## Operation
- Field positions:
  - opcode `[31:27]`
  - rd `[26:22]`
  - rs `[21:17]`
  - rt `[16:12]`
- Source select (A, B):
  - R-type 00000: (rs, rt)
  - addi 00101, lw 01000: (rs, 0)
  - sw 00111: (rs, rd)
  - bne 00010, blt 00110: (rd, rs)
  - jr 00100: (rd, 0)
  - bex 10110: (30, 0)
  - j/jal/setx/others: (0, 0)
- `ctrl_readRegA`/`ctrl_readRegB` are the selected sources; they are driven even when `fd_valid`=0.
- Load-use hazard (`lu`): all of the following hold:
  - `dx_valid`=1
  - `dx_insn` opcode is lw
  - dx rd ≠ 0
  - `fd_valid`=1
  - dx rd equals a used (nonzero) source of `fd_insn`
- Per-cycle action, priority highest first:
  1. Reset: D/X becomes the bubble (`dx_insn`=`NOP`, `dx_pc`/`dx_a`/`dx_b`=0, `dx_valid`=0).
  2. `x_flush`: D/X becomes the bubble; `stall_fd`=0. Fetch redirects, and the F/D instruction is discarded upstream.
  3. `x_hold`: D/X retains its value; `stall_fd`=1.
  4. `lu`: D/X becomes the bubble; `stall_fd`=1.
  5. Otherwise D/X loads:
     - `dx_insn` ← `fd_insn` if `fd_valid`, else `NOP`
     - `dx_pc` ← `fd_pc`
     - `dx_a`/`dx_b` ← operand A/B
     - `dx_valid` ← `fd_valid`
     - `stall_fd`=0
- `stall_fd` is combinational from the current inputs and D/X state.
- Operand values:
  - A selected source of 0 yields 0 regardless of the register file.
  - Otherwise the operand is `data_readRegA`/`data_readRegB`, subject to Configuration.

## Timing
- Latency: 1 cycle. `fd_insn` sampled at edge N appears on `dx_*` after edge N.
- Reset is asynchronous: the bubble appears on `dx_*` immediately on `ctrl_reset` assertion.
- Reset mid-hold or mid-stall discards all state; nothing is replayed.
- A load-use stall lasts exactly 1 cycle, because the bubble clears the lw from D/X.
- `x_hold` with `lu` true: the hold wins; `lu` is re-evaluated after the hold releases.
- `x_flush` with `x_hold`: the flush wins.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: for each operand, if `w_we`=1, `w_rd`≠0 and `w_rd` equals the selected source, the operand takes `w_data` instead of register file data. This covers a same-cycle write and read.
- `DECODE_WB_BYPASS_EN` undefined: operands come only from register file data. The write-before-read ordering must then be guaranteed by the register file clocking.

## Structure
- Shared package `proc_pkg`:
  - opcode constants
  - field bit positions
  - `NOP` value
  - r30 (status) index
- Sub-module `decode_src_select`: combinational source select plus a used-source flag for each port. It is reused by the hazard logic.

## Test plan
- Reset asserted mid-stream -> `dx_valid`=0, `dx_insn`=0, `stall_fd`=0 immediately, without waiting for a clock edge.
- `fd_insn`=add r3,r1,r2 with r1=5, r2=7 -> `ctrl_readRegA`=1, `ctrl_readRegB`=2; after 1 edge `dx_a`=5, `dx_b`=7, `dx_valid`=1.
- D/X holds lw r4 while F/D holds add r5,r4,r1 -> `stall_fd`=1 for exactly 1 cycle; a bubble enters D/X; the add enters the cycle after.
- D/X holds lw r0 while F/D reads r0 -> no stall; the r0 operand reads as 0.
- `x_hold`=1 for 3 cycles -> D/X unchanged and `stall_fd`=1 for all 3; `x_flush` asserted together with `x_hold` -> bubble, `stall_fd`=0.
- With `DECODE_WB_BYPASS_EN`: `w_we`=1, `w_rd`=6, `w_data`=0xDEAD and F/D holds sw r6,0(r1) -> `dx_b`=0xDEAD. Without the macro, `dx_b`=register file value.
